// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline control unit:
//               controller state encoding, stall vector encodings, the eret
//               exception code and the flush target PC helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Controller states
  typedef enum logic [0:0] {
    CTRL_RUN        = 1'b0,
    CTRL_FLUSH_WAIT = 1'b1
  } ctrl_state_e;

  // Stall vector encodings: bit0=PC, bit1=IF, bit2=ID, bit3=EX, bit4=MEM, bit5=WB.
  // A stall at stage N freezes that stage and everything upstream of it.
  localparam logic [5:0] C_STALL_NONE = 6'b000000;
  localparam logic [5:0] C_STALL_IF   = 6'b000011;
  localparam logic [5:0] C_STALL_ID   = 6'b000111;
  localparam logic [5:0] C_STALL_EX   = 6'b001111;
  localparam logic [5:0] C_STALL_MEM  = 6'b011111;

  localparam logic [31:0] C_EXC_ERET  = 32'h0000000e;
  localparam logic [31:0] C_ZERO_WORD = 32'h00000000;

  // eret returns to the saved EPC; every other exception enters the vector.
  function automatic logic [31:0] sel_new_pc(input logic [31:0] etype,
                                             input logic [31:0] epc,
                                             input logic [31:0] vec);
    return (etype == C_EXC_ERET) ? epc : vec;
  endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Bundle between the pipeline stages and the control unit.
//               master : pipeline side (drives requests/exception, gets stall)
//               slave  : control unit (consumes requests, drives stall/flush)
//   stallreq_from_if/id/ex/mem : per-stage stall requests
//   excepttype, cp0_epc        : exception code from MEM and forwarded EPC
//   mem_busy                   : non-abandonable data bus transaction
//   stall, flush, new_pc       : pipeline controls
//   stall_timeout              : sticky watchdog flag
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic        mem_busy;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;

  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex,
           stallreq_from_mem, excepttype, cp0_epc, mem_busy,
    input  stall, flush, new_pc, stall_timeout
  );

  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex,
           stallreq_from_mem, excepttype, cp0_epc, mem_busy,
    output stall, flush, new_pc, stall_timeout
  );
endinterface : pipe_ctrl_if
`default_nettype wire

// File: rtl/pipe_ctrl_stall_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_stall_watchdog
// Description : Counts consecutive stalled cycles and raises a sticky flag
//               once TIMEOUT of them have elapsed.
//   clk, rst          : clock, synchronous active-high reset
//   flush_wait_i      : controller is waiting to flush (counts every cycle)
//   stall_i, flush_i  : current pipeline controls
//   stall_timeout_o   : sticky timeout flag, cleared only by rst
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_wait_i,
  input  logic [5:0] stall_i,
  input  logic       flush_i,
  output logic       stall_timeout_o
);

  localparam logic [15:0] C_WD_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;
  logic        wd_inc;

  // A deferred flush is a stall episode in its own right, including the
  // flush cycle itself, so FLUSH_WAIT always counts.
  assign wd_inc = flush_wait_i | ((stall_i != C_STALL_NONE) & ~flush_i);

  always_comb begin
    wd_cnt_d  = 16'd0;
    timeout_d = timeout_q;
    if (wd_inc) begin
      wd_cnt_d = (wd_cnt_q == 16'hFFFF) ? wd_cnt_q : wd_cnt_q + 16'd1;
      if (wd_cnt_q == C_WD_LAST) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_timeout_o = timeout_q;

endmodule : pipe_ctrl_stall_watchdog
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline control unit. Merges stage stall requests into the
//               stall vector, sequences exception flushes (deferring them
//               while a data bus transaction is outstanding) and hosts the
//               stall watchdog.
//   clk, rst : clock, synchronous active-high reset
//   ctrl_if  : pipe_ctrl_if.slave (requests in, stall/flush/new_pc out)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h00000020,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   ctrl_if
);

  ctrl_state_e state_q, state_d;
  logic [31:0] pend_type_q, pend_type_d;
  logic [31:0] pend_epc_q, pend_epc_d;

  logic [5:0]  stall_comb;
  logic        flush_comb;
  logic [31:0] new_pc_comb;
  logic        timeout_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CTRL_RUN;
      pend_type_q <= C_ZERO_WORD;
      pend_epc_q  <= C_ZERO_WORD;
    end else begin
      state_q     <= state_d;
      pend_type_q <= pend_type_d;
      pend_epc_q  <= pend_epc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_type_d = pend_type_q;
    pend_epc_d  = pend_epc_q;
    stall_comb  = C_STALL_NONE;
    flush_comb  = 1'b0;
    new_pc_comb = C_ZERO_WORD;

    // Outputs are held quiet during reset so nothing downstream moves.
    if (!rst) begin
      case (state_q)
        CTRL_RUN: begin
          if (ctrl_if.excepttype != C_ZERO_WORD) begin
            if (!ctrl_if.mem_busy) begin
              flush_comb  = 1'b1;
              new_pc_comb = sel_new_pc(ctrl_if.excepttype, ctrl_if.cp0_epc,
                                       EXC_VECTOR);
            end else begin
              // Bus cannot be abandoned: freeze everything up to MEM and
              // remember the exception until the transaction retires.
              stall_comb  = C_STALL_MEM;
              pend_type_d = ctrl_if.excepttype;
              pend_epc_d  = ctrl_if.cp0_epc;
              state_d     = CTRL_FLUSH_WAIT;
            end
          end else if (ctrl_if.stallreq_from_mem) begin
            stall_comb = C_STALL_MEM;
          end else if (ctrl_if.stallreq_from_ex) begin
            stall_comb = C_STALL_EX;
          end else if (ctrl_if.stallreq_from_id) begin
            stall_comb = C_STALL_ID;
          end else if (ctrl_if.stallreq_from_if) begin
            stall_comb = C_STALL_IF;
          end
        end

        CTRL_FLUSH_WAIT: begin
          if (ctrl_if.mem_busy) begin
            stall_comb = C_STALL_MEM;
          end else begin
            flush_comb  = 1'b1;
            new_pc_comb = sel_new_pc(pend_type_q, pend_epc_q, EXC_VECTOR);
            state_d     = CTRL_RUN;
          end
        end

        default: state_d = CTRL_RUN;
      endcase
    end
  end

  pipe_ctrl_stall_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk             (clk),
    .rst             (rst),
    .flush_wait_i    (state_q == CTRL_FLUSH_WAIT),
    .stall_i         (stall_comb),
    .flush_i         (flush_comb),
    .stall_timeout_o (timeout_flag)
  );

  assign ctrl_if.stall         = stall_comb;
  assign ctrl_if.flush         = flush_comb;
  assign ctrl_if.new_pc        = new_pc_comb;
  assign ctrl_if.stall_timeout = timeout_flag;

endmodule : pipe_ctrl
`default_nettype wire
